// File: rtl/async_fifo_rd_ctrl_if.sv
// Read-side bus of the dual-clock FIFO: read request, write pointer in,
// and the read address, pointer and status flags out.
interface async_fifo_rd_ctrl_if #(
    parameter int FIFO_ADDR_WD = 3
);
    logic                    rd_en_i;
    logic [FIFO_ADDR_WD:0]   wr_ptr_gray_i;
    logic [FIFO_ADDR_WD-1:0] rd_addr_o;
    logic [FIFO_ADDR_WD:0]   rd_ptr_gray_o;
    logic                    rd_empty_o;
    logic                    rd_aempty_o;
    logic [FIFO_ADDR_WD:0]   rd_level_o;
    logic                    rd_valid_o;
    logic                    rd_underflow_o;

    // Controller side
    modport master (
        input  rd_en_i,
        input  wr_ptr_gray_i,
        output rd_addr_o,
        output rd_ptr_gray_o,
        output rd_empty_o,
        output rd_aempty_o,
        output rd_level_o,
        output rd_valid_o,
        output rd_underflow_o
    );

    // Reader / write-domain side
    modport slave (
        output rd_en_i,
        output wr_ptr_gray_i,
        input  rd_addr_o,
        input  rd_ptr_gray_o,
        input  rd_empty_o,
        input  rd_aempty_o,
        input  rd_level_o,
        input  rd_valid_o,
        input  rd_underflow_o
    );
endinterface

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO. Keeps the read pointer in
// binary and extended Gray form, synchronises the write Gray pointer into
// rd_clk and produces registered empty / almost-empty / level / underflow.
module async_fifo_rd_ctrl #(
    parameter int FIFO_ADDR_WD  = 3,
    parameter int SYNC_STAGES   = 2,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic rd_clk,
    input  logic rd_rstn,
    async_fifo_rd_ctrl_if.master bus
);
    localparam int PW = FIFO_ADDR_WD + 1;
    localparam logic [PW-1:0] AE_LIM = AEMPTY_THRESH[PW-1:0];

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
    logic [PW-1:0] wr_sync;
    logic [PW-1:0] wr_bin_sync;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] rd_bin_next;
    logic [PW-1:0] rd_gray;
    logic [PW-1:0] rd_gray_next;
    logic [PW-1:0] level_next;
    logic [PW-1:0] rd_level;
    logic          rd_empty;
    logic          rd_aempty;
    logic          rd_valid;
    logic          rd_underflow;
    logic          rd_fire;

    // Shift the asynchronous write Gray pointer through the synchroniser chain
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.wr_ptr_gray_i};
        end
    end

    assign wr_sync     = sync_q[SYNC_STAGES-1];
    assign wr_bin_sync = gray2bin(wr_sync);

    // A read is accepted only against the registered empty flag
    assign rd_fire      = bus.rd_en_i & ~rd_empty;
    assign rd_bin_next  = rd_bin + {{(PW-1){1'b0}}, rd_fire};
    assign rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);
    assign level_next   = wr_bin_sync - rd_bin_next;

    // Advance the binary and Gray read pointers together
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            rd_bin  <= '0;
            rd_gray <= '0;
        end else begin
            rd_bin  <= rd_bin_next;
            rd_gray <= rd_gray_next;
        end
    end

    // Status flags computed from the post-read pointer so empty lands on the consuming edge
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            rd_empty     <= 1'b1;
            rd_aempty    <= 1'b1;
            rd_level     <= '0;
            rd_valid     <= 1'b0;
            rd_underflow <= 1'b0;
        end else begin
            rd_empty     <= (rd_gray_next == wr_sync);
            rd_aempty    <= (level_next <= AE_LIM);
            rd_level     <= level_next;
            rd_valid     <= rd_fire;
            rd_underflow <= bus.rd_en_i & rd_empty;
        end
    end

    assign bus.rd_addr_o      = rd_bin[FIFO_ADDR_WD-1:0];
    assign bus.rd_ptr_gray_o  = rd_gray;
    assign bus.rd_empty_o     = rd_empty;
    assign bus.rd_aempty_o    = rd_aempty;
    assign bus.rd_level_o     = rd_level;
    assign bus.rd_valid_o     = rd_valid;
    assign bus.rd_underflow_o = rd_underflow;
endmodule
